// File: rtl/div_module_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The execute stage drives the request side; the divider drives ready/valid/result.
interface div_module_if #(
  parameter int WIDTH = 32
);
  logic             div_input_valid;
  logic [1:0]       div_input_op;
  logic [WIDTH-1:0] div_input_a;
  logic [WIDTH-1:0] div_input_b;
  logic             div_input_kill;
  logic             div_output_ready;
  logic             div_output_valid;
  logic [WIDTH-1:0] div_output_result;

  modport master (
    output div_input_valid, div_input_op, div_input_a, div_input_b, div_input_kill,
    input  div_output_ready, div_output_valid, div_output_result
  );

  modport slave (
    input  div_input_valid, div_input_op, div_input_a, div_input_b, div_input_kill,
    output div_output_ready, div_output_valid, div_output_result
  );
endinterface

// File: rtl/div_module.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract, one quotient bit per
// cycle, fixed latency regardless of operands; kill and reset abort without a result pulse.
module div_module #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  div_module_if.slave  dif
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic                    prep;
  logic [WIDTH-1:0]        result_q;

  logic [1:0]              op_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic                    b_zero, ovf, neg_q, neg_r;
  logic [WIDTH-1:0]        quo, dvsr, rem;

  logic                    accept;
  logic [WIDTH:0]          rem_sh, diff;
  logic                    q_bit;
  logic [WIDTH-1:0]        rem_step, quo_step, final_res;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic en);
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exactly right as an unsigned magnitude
    return (en && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign accept = (state == IDLE) && dif.div_input_valid && !dif.div_input_kill;

  assign dif.div_output_ready  = (state == IDLE);
  assign dif.div_output_valid  = (state == DONE) && !dif.div_input_kill;
  assign dif.div_output_result = result_q;

  // One restoring step: borrow out of the WIDTH+1 bit subtract means the trial failed
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvsr};
    q_bit    = ~diff[WIDTH];
    rem_step = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], q_bit};
  end

  always_comb begin
    final_res = op_q[1] ? apply_sign(rem_step, neg_r) : apply_sign(quo_step, neg_q);
    if (b_zero)
      final_res = op_q[1] ? $unsigned(a_q) : '1;
    else if (ovf)
      final_res = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = DIVIDE;
      DIVIDE:  if (dif.div_input_kill)       state_nxt = IDLE;
               else if (!prep && cnt == '0)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prep     <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt  <= CW'(WIDTH - 1);
        prep <= 1'b1;
      end else if (state == DIVIDE) begin
        prep <= 1'b0;
        if (!prep && cnt != '0) cnt <= cnt - 1'b1;
      end
      if (state == DIVIDE && state_nxt == DONE) result_q <= final_res;
    end
  end

  // Operands are latched raw; magnitudes are formed in the first DIVIDE cycle so the
  // accept path carries no negation, and that cycle brings latency to WIDTH+1.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= dif.div_input_op;
      a_q    <= $signed(dif.div_input_a);
      b_q    <= $signed(dif.div_input_b);
      b_zero <= (dif.div_input_b == '0);
      ovf    <= !dif.div_input_op[0] && (dif.div_input_a == {1'b1, {(WIDTH-1){1'b0}}})
                && (dif.div_input_b == '1);
      neg_q  <= !dif.div_input_op[0] && (dif.div_input_b != '0)
                && (dif.div_input_a[WIDTH-1] ^ dif.div_input_b[WIDTH-1]);
      neg_r  <= !dif.div_input_op[0] && dif.div_input_a[WIDTH-1];
    end
    if (state == DIVIDE) begin
      if (prep) begin
        quo  <= abs_val(a_q, !op_q[0]);
        dvsr <= abs_val(b_q, !op_q[0]);
        rem  <= '0;
      end else begin
        quo  <= quo_step;
        rem  <= rem_step;
      end
    end
  end
endmodule

// File: tb/tb_div_module.sv
// Bench for div_module: arithmetic reference model with an expected-result queue checked
// every cycle, plus directed vectors with hand-computed results and latency.
module tb_div_module;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  div_module_if #(.WIDTH(W)) dif();

  div_module #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  bit   armed = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   busy_m;
  exp_t e_m;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    if (op[0]) begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    if (y == 0) begin
      q = -1;
      r = x;
    end else begin
      q = x / y;
      r = x % y;
    end
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  // Model: one op in flight at a time; result due WIDTH+1 edges after the accepting edge.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      armed = 1'b1;
    end else begin
      busy_m = (exp_q.size() != 0);
      if (busy_m && dif.div_input_kill)
        exp_q.delete();
      else if (busy_m && cyc == exp_q[0].due + 1)
        void'(exp_q.pop_front());
      if (!busy_m && dif.div_input_valid && !dif.div_input_kill) begin
        e_m.res = ref_div(dif.div_input_op, dif.div_input_a, dif.div_input_b);
        e_m.due = cyc + W + 1;
        exp_q.push_back(e_m);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    bit seen;
    @(posedge clk); #1;
    dif.div_input_valid = 1'b1;
    dif.div_input_op    = op;
    dif.div_input_a     = a;
    dif.div_input_b     = b;
    @(posedge clk); #1;
    dif.div_input_valid = 1'b0;
    dif.div_input_op    = ~op;
    dif.div_input_a     = $urandom;
    dif.div_input_b     = $urandom;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      if (dif.div_output_valid) seen = 1'b1;
      else n++;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_lat"}, n, 33);
      chk(nm, dif.div_output_result, exp);
      @(negedge clk);
      chk({nm, "_ready_after"}, {31'b0, dif.div_output_ready}, 32'd1);
      chk({nm, "_single_pulse"}, {31'b0, dif.div_output_valid}, 32'd0);
    end
  endtask

  task automatic count_pulses(input int ncyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (dif.div_output_valid) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int ra, rb;
    dif.div_input_valid = 1'b0;
    dif.div_input_op    = 2'b00;
    dif.div_input_a     = '0;
    dif.div_input_b     = '0;
    dif.div_input_kill  = 1'b0;

    fork
      forever begin
        logic ev;
        @(negedge clk);
        if (armed) begin
          ev = (exp_q.size() != 0) && (cyc == exp_q[0].due) && !dif.div_input_kill;
          chk("ready", {31'b0, dif.div_output_ready}, {31'b0, exp_q.size() == 0});
          chk("valid", {31'b0, dif.div_output_valid}, {31'b0, ev});
          if (ev) chk("result", dif.div_output_result, exp_q[0].res);
        end
      end
    join_none

    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, dif.div_output_ready}, 32'd1);
    chk("rst_valid", {31'b0, dif.div_output_valid}, 32'd0);
    chk("rst_result", dif.div_output_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    chk("pin_divu", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
    chk("pin_div", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div_ovf", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin_rem_b0", ref_div(2'b10, 32'd5, 32'd0), 32'd5);

    run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14);
    run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    run_op("remu_7_max",   2'b11, 32'd7,          32'hFFFF_FFFF,  32'd7);
    run_op("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD);
    run_op("rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1);
    run_op("div_5_0",      2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF);
    run_op("rem_5_0",      2'b10, 32'd5,          32'd0,          32'd5);
    run_op("divu_0_0",     2'b01, 32'd0,          32'd0,          32'hFFFF_FFFF);
    run_op("rem_m7_0",     2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9);
    run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    run_op("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);

    // Kill ten cycles into the divide
    @(posedge clk); #1;
    dif.div_input_valid = 1'b1;
    dif.div_input_op    = 2'b01;
    dif.div_input_a     = 32'd1000;
    dif.div_input_b     = 32'd3;
    @(posedge clk); #1;
    dif.div_input_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 dif.div_input_kill = 1'b1;
    @(posedge clk); #1;
    dif.div_input_kill = 1'b0;
    @(negedge clk);
    chk("kill_ready_next", {31'b0, dif.div_output_ready}, 32'd1);
    count_pulses(40, pulses);
    chk("kill_no_valid", pulses, 0);
    run_op("divu_9_3_after_kill", 2'b01, 32'd9, 32'd3, 32'd3);

    // Reset pulsed mid-divide
    @(posedge clk); #1;
    dif.div_input_valid = 1'b1;
    dif.div_input_op    = 2'b00;
    dif.div_input_a     = 32'd12345;
    dif.div_input_b     = 32'hFFFF_FFF9;
    @(posedge clk); #1;
    dif.div_input_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, dif.div_output_ready}, 32'd1);
    chk("midrst_valid", {31'b0, dif.div_output_valid}, 32'd0);
    chk("midrst_result", dif.div_output_result, 32'd0);
    count_pulses(40, pulses);
    chk("midrst_no_valid", pulses, 0);

    // Valid held high: further requests are taken only once the unit is idle again
    @(posedge clk); #1;
    dif.div_input_valid = 1'b1;
    dif.div_input_op    = 2'b01;
    dif.div_input_a     = 32'd50;
    dif.div_input_b     = 32'd5;
    count_pulses(80, pulses);
    chk("held_pulses", pulses, 2);
    @(posedge clk); #1;
    dif.div_input_valid = 1'b0;
    repeat (45) @(posedge clk);

    // Random traffic with biased special operands, occasional kills
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #1;
      ra = $urandom_range(0, 7);
      rb = $urandom_range(0, 7);
      dif.div_input_valid = ($urandom_range(0, 3) != 0);
      dif.div_input_op    = 2'($urandom_range(0, 3));
      dif.div_input_a     = (ra == 0) ? 32'h8000_0000 :
                            (ra == 1) ? 32'($urandom_range(0, 20)) : $urandom;
      dif.div_input_b     = (rb == 0) ? 32'd0 :
                            (rb == 1) ? 32'hFFFF_FFFF :
                            (rb == 2) ? 32'($urandom_range(1, 15)) : $urandom;
      dif.div_input_kill  = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    dif.div_input_valid = 1'b0;
    dif.div_input_kill  = 1'b0;
    repeat (50) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
